adder_pipelined: RTL and testbench
==================================

// Module: adder_pipelined
// PURPOSE
//  Parametrised, pipelined ripple-carry adder/subtractor with valid/ready handshakes.
//  Successor to the fixed 3-bit combinational adder.
//  Splits a WIDTH-bit add into STAGES chunk-adds with one register per stage, so
//  WIDTH can grow without lengthening the critical path.
//  Sits between streaming operand producers and consumers in the datapath.
// PARAMETERS
//  WIDTH   8  operand/sum width in bits; must be a multiple of STAGES
//  STAGES  2  pipeline depth = number of chunks; CHUNK = WIDTH/STAGES bits each
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands a, b, cin, sub are valid this cycle
//  in_ready   out  1      adder accepts operands; transfer when in_valid & in_ready
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry in (add) / borrow in (sub)
//  sub        in   1      0: s = a+b+cin;  1: s = a-b-cin
//  out_valid  out  1      s, cout, overflow are valid
//  out_ready  in   1      consumer accepts result; transfer when out_valid & out_ready
//  s          out  WIDTH  sum/difference mod 2**WIDTH
//  cout       out  1      carry out of bit WIDTH-1 (in sub mode 1 = no borrow)
//  overflow   out  1      two's-complement signed overflow of the operation
// BEHAVIOUR
//  - Operand prep at accept: b_eff = b ^ {WIDTH{sub}}, c_eff = cin ^ sub.
//    Sub becomes a + ~b + ~cin = a - b - cin.
//  - Stage i (0..STAGES-1) adds chunk i of a and b_eff plus the carry from stage i-1.
//    Stage 0 uses c_eff. Result chunk and carry are registered.
//    Unconsumed upper chunks of a and b_eff travel with the stage valid bit.
//  - overflow = (a[W-1] == b_eff[W-1]) && (s[W-1] != a[W-1]), computed in the last stage.
//  - Latency: operands accepted at edge k produce out_valid=1 after edge k+STAGES
//    when no stall occurs. Throughput is 1 operation per cycle.
//  - Stall: stall = out_valid & ~out_ready.
//    While stalled, all stage registers (data and valid) hold.
//    in_ready = ~stall, a combinational function of out_valid and out_ready only.
//    in_ready never depends on in_valid.
//  - Bubbles: a stage with valid=0 still advances when not stalled, so bubbles collapse
//    only at the output. No skid buffer.
//  - Outputs are held stable while out_valid & ~out_ready.
//  - Reset (async, any time, including mid-operation): all stage valid bits = 0,
//    out_valid = 0, s = 0, cout = 0, overflow = 0. in_ready = 1 while rst is high.
//    In-flight operations are discarded, never emitted.
//    First accept is possible at the first edge after rst deasserts.
//  - Simultaneous out handshake and in accept in the same cycle: the pipeline advances
//    one stage. No operation is lost or duplicated.
//  - STAGES=1 degenerates to a registered full-width adder with latency 1.
// STRUCTURE
//  - Shared package adder_pkg:
//    typedef enum logic {OP_ADD=1'b0, OP_SUB=1'b1} adder_op_t;
//    function chunk_bits(WIDTH, STAGES).
//  - Sub-module adder_chunk #(CHUNK): combinational CHUNK-bit ripple adder
//    (a, b, cin -> s, cout), instantiated STAGES times via a generate loop.
//  - Top: generate-loop stage registers, stall logic, operand prep, overflow.
//  - Elaboration-time check: WIDTH % STAGES == 0.
// TESTING
//  Default WIDTH=8, STAGES=2 unless noted. A behavioural model computes
//  {cout,s} = a + b_eff + c_eff, with expected results queued by latency and checked
//  with ===. The bench prints a FAILURE/SUCCESS banner with the error count.
//  1. Add 8'hFF + 8'h01, cin=0 -> s=8'h00, cout=1, overflow=0; out_valid exactly 2 cycles after accept.
//  2. Add 8'h7F + 8'h01 -> s=8'h80, cout=0, overflow=1.
//     Sub 8'h80 - 8'h01, cin=0 -> s=8'h7F, cout=1, overflow=1.
//  3. Sub 8'h05 - 8'h07, cin=0 -> s=8'hFE, cout=0, overflow=0.
//     Sub 8'h05 - 8'h03, cin=1 -> s=8'h01, cout=1.
//  4. Back-to-back stream of 6 ops, out_ready low for 3 cycles mid-stream
//     -> in_ready=0 during stall, outputs frozen, all 6 results in order, none dropped.
//  5. rst pulse with 2 ops in flight -> out_valid=0 immediately (async),
//     s/cout/overflow=0, no stale result after release.
//  6. WIDTH=4, STAGES=2: exhaustive a, b, cin, sub (1024 ops), out_ready randomly toggled
//     -> zero mismatches.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and sizing helpers for the pipelined adder
package adder_pkg;

   // Operation select as seen on the sub input
   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } adder_op_t;

   // Width of one pipeline chunk; callers guarantee width is a multiple of stages
   function automatic int chunk_bits(input int width, input int stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - combinational CHUNK-bit ripple-carry adder slice
module adder_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   logic carry;

   // Bit-serial ripple: each sum bit uses the carry produced by the bit below
   always_comb begin
      carry = cin;
      s     = '0;
      for (int k = 0; k < CHUNK; k++) begin
         s[k]  = a[k] ^ b[k] ^ carry;
         carry = (a[k] & b[k]) | (carry & (a[k] ^ b[k]));
      end
      cout = carry;
   end

endmodule

// File: rtl/adder_pipelined.sv
// rtl/adder_pipelined.sv - pipelined adder/subtractor with valid/ready handshakes
module adder_pipelined
   import adder_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             overflow
);

   localparam int CHUNK = chunk_bits(WIDTH, STAGES);

   if ((STAGES < 1) || (WIDTH % STAGES != 0)) begin : g_width_check
      $error("adder_pipelined: WIDTH must be a non-zero multiple of STAGES");
   end

   // Rank 0 is the operand register filled at accept; rank i+1 holds the
   // result of chunk stage i. The last rank drives the outputs.
   logic [STAGES:0]    vld_q;

   // Operands presented to stage i (b already conditioned for subtraction)
   logic [WIDTH-1:0]   opa_q [STAGES];
   logic [WIDTH-1:0]   opb_q [STAGES];
   logic               c0_q;

   // Partial sum and carry produced by stage i
   logic [WIDTH-1:0]   s_q   [STAGES];
   logic [WIDTH-1:0]   s_d   [STAGES];
   logic [STAGES-1:0]  c_q;
   logic [STAGES-1:0]  c_d;
   logic [CHUNK-1:0]   ch_s  [STAGES];

   logic               ovf_q;
   logic               ovf_d;

   logic               stall;
   logic               accept;
   adder_op_t          op;
   logic [WIDTH-1:0]   b_eff;
   logic               c_eff;

   // The whole pipe freezes only when the output holds a result nobody takes
   assign stall    = vld_q[STAGES] & ~out_ready;
   assign in_ready = ~stall;
   assign accept   = in_valid & in_ready;

   // Subtraction is a + ~b + ~cin, so invert b and the incoming carry
   assign op    = adder_op_t'(sub);
   assign b_eff = (op == OP_SUB) ? ~b : b;
   assign c_eff = (op == OP_SUB) ? ~cin : cin;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic             cin_w;
      logic [WIDTH-1:0] part_w;

      if (i == 0) begin : g_first
         assign cin_w  = c0_q;
         assign part_w = '0;
      end else begin : g_rest
         assign cin_w  = c_q[i-1];
         assign part_w = s_q[i-1];
      end

      adder_chunk #(
         .CHUNK (CHUNK)
      ) u_chunk (
         .a    (opa_q[i][i*CHUNK +: CHUNK]),
         .b    (opb_q[i][i*CHUNK +: CHUNK]),
         .cin  (cin_w),
         .s    (ch_s[i]),
         .cout (c_d[i])
      );

      // Lower chunks come from earlier stages; chunk i and above are still zero
      assign s_d[i] = part_w | (WIDTH'(ch_s[i]) << (i * CHUNK));
   end

   // Sign-bit rule on the conditioned operands, resolved where the top chunk is added
   assign ovf_d = (opa_q[STAGES-1][WIDTH-1] == opb_q[STAGES-1][WIDTH-1]) &&
                  (ch_s[STAGES-1][CHUNK-1] != opa_q[STAGES-1][WIDTH-1]);

   // Pipeline ranks: cleared by reset, frozen on stall, otherwise shift one rank
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         c0_q  <= 1'b0;
         c_q   <= '0;
         ovf_q <= 1'b0;
         for (int i = 0; i < STAGES; i++) begin
            opa_q[i] <= '0;
            opb_q[i] <= '0;
            s_q[i]   <= '0;
         end
      end else if (!stall) begin
         vld_q[0] <= accept;
         opa_q[0] <= a;
         opb_q[0] <= b_eff;
         c0_q     <= c_eff;
         for (int i = 0; i < STAGES; i++) begin
            vld_q[i+1] <= vld_q[i];
            s_q[i]     <= s_d[i];
         end
         for (int i = 1; i < STAGES; i++) begin
            opa_q[i] <= opa_q[i-1];
            opb_q[i] <= opb_q[i-1];
         end
         c_q   <= c_d;
         ovf_q <= ovf_d;
      end
   end

   assign out_valid = vld_q[STAGES];
   assign s         = s_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_adder_pipelined.sv
// tb/tb_adder_pipelined.sv - scoreboard bench for adder_pipelined (8/2 and 4/2)
module tb_adder_pipelined;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   // 8-bit, 2-stage instance
   logic       iv8, ir8, cin8, sub8, ov8, or8, co8, of8;
   logic [7:0] a8, b8, s8;

   // 4-bit, 2-stage instance
   logic       iv4, ir4, cin4, sub4, ov4, or4, co4, of4;
   logic [3:0] a4, b4, s4;

   adder_pipelined #(.WIDTH(8), .STAGES(2)) dut8 (
      .clk(clk), .rst(rst),
      .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
      .out_valid(ov8), .out_ready(or8), .s(s8), .cout(co8), .overflow(of8)
   );

   adder_pipelined #(.WIDTH(4), .STAGES(2)) dut4 (
      .clk(clk), .rst(rst),
      .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
      .out_valid(ov4), .out_ready(or4), .s(s4), .cout(co4), .overflow(of4)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [9:0] q8[$];
   logic [5:0] q4[$];
   logic [9:0] exp8;
   logic [5:0] exp4;
   logic [9:0] snap8;
   logic [7:0] ra, rb;
   logic       rc, rs;
   bit         done4;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: {overflow, cout, s}
   function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic c, input logic sb);
      logic [7:0] be;
      logic [8:0] sm;
      be = sb ? ~b : b;
      sm = {1'b0, a} + {1'b0, be} + 9'(c ^ sb);
      return {(a[7] == be[7]) && (sm[7] != a[7]), sm[8], sm[7:0]};
   endfunction

   function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b,
                                         input logic c, input logic sb);
      logic [3:0] be;
      logic [4:0] sm;
      be = sb ? ~b : b;
      sm = {1'b0, a} + {1'b0, be} + 5'(c ^ sb);
      return {(a[3] == be[3]) && (sm[3] != a[3]), sm[4], sm[3:0]};
   endfunction

   // Output monitors: compare on every completed output handshake
   always @(negedge clk) begin
      if (!rst && ov8 && or8) begin
         if (q8.size() == 0) check("dut8_spurious_output", 1, 0);
         else begin
            exp8 = q8.pop_front();
            check("dut8_result", {of8, co8, s8}, exp8);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && ov4 && or4) begin
         if (q4.size() == 0) check("dut4_spurious_output", 1, 0);
         else begin
            exp4 = q4.pop_front();
            check("dut4_result", {of4, co4, s4}, exp4);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic sb, input logic [9:0] e);
      bit done = 0;
      iv8 = 1'b1; a8 = a; b8 = b; cin8 = c; sub8 = sb;
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge clk);
         if (ir8) begin
            q8.push_back(e);
            done = 1;
         end
         @(posedge clk); #1;
      end
      iv8 = 1'b0;
      if (!done) check("send8_timeout", 0, 1);
   endtask

   task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic c,
                        input logic sb);
      bit done = 0;
      iv4 = 1'b1; a4 = a; b4 = b; cin4 = c; sub4 = sb;
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge clk);
         if (ir4) begin
            q4.push_back(model4(a, b, c, sb));
            done = 1;
         end
         @(posedge clk); #1;
      end
      iv4 = 1'b0;
      if (!done) check("send4_timeout", 0, 1);
   endtask

   task automatic drain8(input string tag);
      for (int n = 0; n < 50 && q8.size() != 0; n++) begin
         @(posedge clk); #1;
      end
      check(tag, q8.size(), 0);
   endtask

   task automatic drain4(input string tag);
      for (int n = 0; n < 500 && q4.size() != 0; n++) begin
         @(posedge clk); #1;
      end
      check(tag, q4.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      iv8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; or8 = 1;
      iv4 = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0; or4 = 1;
      done4 = 0;
      #2;
      check("reset_out_valid", ov8, 0);
      check("reset_in_ready", ir8, 1);
      check("reset_sum", {of8, co8, s8}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: carry out of the top bit and the two-cycle latency
      send8(8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00});
      @(negedge clk);
      check("t1_valid_after_accept", ov8, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("t1_valid_after_1_edge", ov8, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("t1_valid_after_2_edges", ov8, 1);
      @(posedge clk); #1;

      // 2/3: signed overflow cases and subtraction with borrow
      send8(8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80});
      send8(8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F});
      send8(8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 1'b0, 8'hFE});
      send8(8'h05, 8'h03, 1'b1, 1'b1, {1'b0, 1'b1, 8'h01});
      drain8("t23_drain");

      // 4: six back-to-back ops with a three-cycle output stall mid-stream
      fork
         begin
            for (int k = 0; k < 6; k++) begin
               ra = 8'($urandom); rb = 8'($urandom);
               rc = 1'($urandom); rs = 1'($urandom);
               send8(ra, rb, rc, rs, model8(ra, rb, rc, rs));
            end
         end
         begin
            repeat (3) @(posedge clk);
            #1 or8 = 1'b0;
            @(negedge clk);
            snap8 = {of8, co8, s8};
            for (int j = 0; j < 3; j++) begin
               if (j != 0) @(negedge clk);
               check("t4_stall_valid", ov8, 1);
               check("t4_stall_in_ready", ir8, 0);
               check("t4_stall_frozen", {of8, co8, s8}, snap8);
               @(posedge clk); #1;
            end
            or8 = 1'b1;
         end
      join
      drain8("t4_all_results");

      // 5: reset with one result held at the output and one still in flight
      or8 = 1'b0;
      send8(8'h11, 8'h22, 1'b0, 1'b0, 10'h033);
      send8(8'h40, 8'h40, 1'b0, 1'b0, 10'h280);
      for (int n = 0; n < 20 && !ov8; n++) begin
         @(posedge clk); #1;
      end
      check("t5_pre_reset_valid", ov8, 1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("t5_reset_out_valid", ov8, 0);
      check("t5_reset_outputs", {of8, co8, s8}, 0);
      check("t5_reset_in_ready", ir8, 1);
      q8.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      or8 = 1'b1;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         check("t5_no_stale_result", ov8, 0);
      end
      @(posedge clk); #1;

      // 6: exhaustive 4-bit sweep under random backpressure
      fork
         begin
            for (int sb = 0; sb < 2; sb++)
               for (int c = 0; c < 2; c++)
                  for (int x = 0; x < 16; x++)
                     for (int y = 0; y < 16; y++)
                        send4(4'(x), 4'(y), 1'(c), 1'(sb));
            done4 = 1;
         end
         begin
            while (!done4) begin
               @(posedge clk); #1;
               or4 = 1'($urandom_range(0, 1));
            end
            or4 = 1'b1;
         end
      join
      drain4("t6_exhaustive_drain");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
